// File: rtl/text_banner_if.sv
// Pixel-lookup, message-write and status signals between the VGA timing side and text_banner.
interface text_banner_if;
  logic        frame_start;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        show;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [6:0]  wr_char;
  logic        text_on;
  logic [10:0] rom_addr;
  logic [2:0]  bit_addr;
  logic        busy;

  modport master (
    output frame_start, pixel_x, pixel_y, show, wr_en, wr_idx, wr_char,
    input  text_on, rom_addr, bit_addr, busy
  );

  modport slave (
    input  frame_start, pixel_x, pixel_y, show, wr_en, wr_idx, wr_char,
    output text_on, rom_addr, bit_addr, busy
  );
endinterface

// File: rtl/text_banner.sv
// Text overlay: writable message, origin/scale mapping to 8x16 font-ROM address, typewriter reveal.
// Optional blinking in SHOW is built when TEXT_BANNER_BLINK_EN is defined.
module text_banner #(
  parameter int MSG_LEN       = 8,
  parameter int SCALE_LOG2    = 2,
  parameter int X0            = 160,
  parameter int Y0            = 128,
  parameter int REVEAL_FRAMES = 6,
  parameter int BLINK_FRAMES  = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  text_banner_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REVEAL, SHOW} state_e;

  localparam logic [11:0] SPAN_X = 12'((MSG_LEN * 8) << SCALE_LOG2);
  localparam logic [11:0] SPAN_Y = 12'(16 << SCALE_LOG2);

  state_e      state_q, state_d;
  logic [5:0]  rc_q, rc_d;
  logic [15:0] frm_q, frm_d;
  logic [6:0]  slot_q [MSG_LEN];
  logic        blink_q;

  logic        text_on_q;
  logic [10:0] rom_addr_q;
  logic [2:0]  bit_addr_q;
  logic        busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rc_q    <= '0;
      frm_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      frm_q   <= frm_d;
      busy_q  <= (state_d == REVEAL);
    end
  end

  // Transitions only on frame_start so the visible banner never changes mid-frame.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    frm_d   = frm_q;
    if (bus.frame_start) begin
      if (state_q != IDLE && !bus.show) begin
        state_d = IDLE;
        rc_d    = '0;
        frm_d   = '0;
      end else begin
        case (state_q)
          IDLE: if (bus.show) begin
            state_d = REVEAL;
            rc_d    = 6'd1;
            frm_d   = '0;
          end
          REVEAL: begin
            if (rc_q >= 6'(MSG_LEN)) begin
              state_d = SHOW;
            end else if (frm_q == 16'(REVEAL_FRAMES - 1)) begin
              frm_d = '0;
              rc_d  = rc_q + 6'd1;
              if (rc_q + 6'd1 == 6'(MSG_LEN)) state_d = SHOW;
            end else begin
              frm_d = frm_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TEXT_BANNER_BLINK_EN
  logic [15:0] bcnt_q, bcnt_d;
  logic        blink_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (state_d == SHOW && state_q != SHOW) begin
      bcnt_d  = '0;
      blink_d = 1'b1;
    end else if (state_d == SHOW) begin
      if (bus.frame_start) begin
        if (bcnt_q == 16'(BLINK_FRAMES - 1)) begin
          bcnt_d  = '0;
          blink_d = ~blink_q;
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
      end
    end else begin
      bcnt_d  = '0;
      blink_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end
`else
  assign blink_q = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) slot_q[i] <= '0;
    end else if (bus.wr_en) begin
      for (int i = 0; i < MSG_LEN; i++)
        if (bus.wr_idx == 5'(i)) slot_q[i] <= bus.wr_char;
    end
  end

  logic [9:0] rx_c, ry_c;
  logic       inside_c;
  logic [6:0] idx_c, char_c;
  logic [2:0] col_c;
  logic [3:0] row_c;

  always_comb begin
    rx_c     = bus.pixel_x - 10'(X0);
    ry_c     = bus.pixel_y - 10'(Y0);
    inside_c = (bus.pixel_x >= 10'(X0)) && ({2'b0, rx_c} < SPAN_X) &&
               (bus.pixel_y >= 10'(Y0)) && ({2'b0, ry_c} < SPAN_Y);
    idx_c    = 7'(rx_c >> (3 + SCALE_LOG2));
    col_c    = 3'(rx_c >> SCALE_LOG2);
    row_c    = 4'(ry_c >> SCALE_LOG2);
    char_c   = '0;
    for (int i = 0; i < MSG_LEN; i++)
      if (idx_c == 7'(i)) char_c = slot_q[i];
  end

  // Single output stage: everything lines up one clock after the pixel coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      text_on_q  <= 1'b0;
      rom_addr_q <= '0;
      bit_addr_q <= '0;
    end else begin
      text_on_q  <= inside_c && (state_q != IDLE) && (idx_c < {1'b0, rc_q}) &&
                    (char_c != 7'd0) && blink_q;
      rom_addr_q <= inside_c ? {char_c, row_c} : 11'd0;
      bit_addr_q <= inside_c ? col_c : 3'd0;
    end
  end

  assign bus.text_on  = text_on_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.bit_addr = bit_addr_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_text_banner.sv
// Directed bench for text_banner: reference model plus scoreboard queue of expected pixel outputs.
module tb_text_banner;
  localparam int MSG_LEN = 8, SCALE_LOG2 = 2, X0 = 160, Y0 = 128;
  localparam int REVEAL_FRAMES = 6, BLINK_FRAMES = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  text_banner_if bus();

  text_banner #(
    .MSG_LEN(MSG_LEN), .SCALE_LOG2(SCALE_LOG2), .X0(X0), .Y0(Y0),
    .REVEAL_FRAMES(REVEAL_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    string       tag;
    logic        on;
    logic [10:0] addr;
    logic [2:0]  bits;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int         m_state = 0;
  int         m_rc = 0, m_frm = 0, m_bc = 0;
  logic       m_blink = 1'b1;
  logic [6:0] m_slot [MSG_LEN];
  int         frame_n = 0;
  int         fall_frame = 0;

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_px(input int x, input int y, input string tag);
    exp_t e;
    int rx, ry, idx;
    logic [3:0] r;
    logic [6:0] ch;
    e.tag = tag; e.on = 1'b0; e.addr = '0; e.bits = '0;
    rx = x - X0;
    ry = y - Y0;
    if (x >= X0 && rx < MSG_LEN * 8 * (1 << SCALE_LOG2) && y >= Y0 && ry < 16 * (1 << SCALE_LOG2)) begin
      idx    = rx / (8 * (1 << SCALE_LOG2));
      r      = 4'((ry / (1 << SCALE_LOG2)) % 16);
      ch     = m_slot[idx];
      e.addr = {ch, r};
      e.bits = 3'((rx / (1 << SCALE_LOG2)) % 8);
      e.on   = (m_state != 0) && (idx < m_rc) && (ch != 7'd0) && m_blink;
    end
    return e;
  endfunction

  task automatic model_frame();
    int prev = m_state;
    if (m_state != 0 && !bus.show) begin
      m_state = 0; m_rc = 0; m_frm = 0;
    end else if (m_state == 0 && bus.show) begin
      m_state = 1; m_rc = 1; m_frm = 0;
    end else if (m_state == 1) begin
      if (m_rc >= MSG_LEN) m_state = 2;
      else if (m_frm == REVEAL_FRAMES - 1) begin
        m_frm = 0; m_rc++;
        if (m_rc == MSG_LEN) m_state = 2;
      end else m_frm++;
    end
`ifdef TEXT_BANNER_BLINK_EN
    if (m_state == 2 && prev != 2) begin
      m_blink = 1'b1; m_bc = 0;
    end else if (m_state == 2) begin
      if (m_bc == BLINK_FRAMES - 1) begin m_bc = 0; m_blink = ~m_blink; end
      else m_bc++;
    end else begin
      m_blink = 1'b1; m_bc = 0;
    end
`else
    if (prev < 0) m_bc = 0;
    m_blink = 1'b1;
`endif
  endtask

  task automatic frame();
    @(negedge clk);
    bus.frame_start = 1'b1;
    model_frame();
    frame_n++;
    @(posedge clk);
    #1;
    chk($sformatf("busy_f%0d", frame_n), 11'(bus.busy), 11'(m_state == 1));
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [6:0] ch);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_idx = idx; bus.wr_char = ch;
    if (int'(idx) < MSG_LEN) m_slot[idx] = ch;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic probe_push(input int x, input int y, input exp_t e);
    exp_t got;
    @(negedge clk);
    bus.pixel_x = 10'(x); bus.pixel_y = 10'(y);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, "_on"},   11'(bus.text_on), 11'(got.on));
    chk({got.tag, "_addr"}, bus.rom_addr,     got.addr);
    chk({got.tag, "_bit"},  11'(bus.bit_addr), 11'(got.bits));
  endtask

  task automatic probe_m(input int x, input int y, input string tag);
    probe_push(x, y, model_px(x, y, tag));
  endtask

  task automatic probe_x(input int x, input int y, input logic on, input logic [10:0] addr,
                         input logic [2:0] bits, input string tag);
    exp_t e;
    e.tag = tag; e.on = on; e.addr = addr; e.bits = bits;
    probe_push(x, y, e);
  endtask

  initial begin
    for (int i = 0; i < MSG_LEN; i++) m_slot[i] = '0;
    bus.frame_start = 0; bus.pixel_x = 10'd160; bus.pixel_y = 10'd128; bus.show = 0;
    bus.wr_en = 0; bus.wr_idx = 0; bus.wr_char = 0;

    #12 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_on",   11'(bus.text_on), 11'd0);
    chk("rst_addr", bus.rom_addr, 11'd0);
    chk("rst_bit",  11'(bus.bit_addr), 11'd0);
    chk("rst_busy", 11'(bus.busy), 11'd0);
    @(negedge clk);
    rst_n = 1'b1;

    wr(5'd0, 7'h44); wr(5'd1, 7'h49); wr(5'd2, 7'h45); wr(5'd3, 7'h44); wr(5'd4, 7'h21);
    wr(5'd13, 7'h5A);

    for (int f = 0; f < 3; f++) begin
      frame();
      probe_x(160, 128, 1'b0, 11'h440, 3'd0, $sformatf("idle_f%0d", f));
    end

    bus.show = 1'b1;
    frame_n = 0;
    frame();
    probe_x(160, 128, 1'b1, 11'h440, 3'd0, "f1_slot0");
    probe_x(192, 128, 1'b0, 11'h490, 3'd0, "f1_slot1");
    probe_x(191, 191, 1'b1, 11'h44F, 3'd7, "f1_corner");
    probe_x(159, 150, 1'b0, 11'h000, 3'd0, "left_edge");
    probe_x(170, 192, 1'b0, 11'h000, 3'd0, "bottom_edge");

    while (frame_n < 6) frame();
    probe_x(192, 128, 1'b0, 11'h490, 3'd0, "f6_slot1");
    frame();
    probe_x(192, 128, 1'b1, 11'h490, 3'd0, "f7_slot1");

    while (frame_n < 46) begin
      frame();
      if (fall_frame == 0 && bus.busy === 1'b0) fall_frame = frame_n;
    end
    chk("busy_fall_frame", 11'(fall_frame), 11'd43);
    probe_x(288, 128, 1'b1, 11'h210, 3'd0, "slot4");
    probe_x(320, 128, 1'b0, 11'h000, 3'd0, "slot5_empty");
    probe_x(384, 140, 1'b0, 11'h003, 3'd0, "slot7_empty");

    for (int f = 0; f < 100; f++) begin
      frame();
      probe_m(160 + 4 * (f % 5), 130, $sformatf("show_f%0d", f));
    end

    @(negedge clk);
    bus.show = 1'b0;
    probe_m(160, 128, "drop_midframe");
    frame();
    probe_x(160, 128, 1'b0, 11'h440, 3'd0, "dropped");
    bus.show = 1'b1;
    frame();
    probe_x(160, 128, 1'b1, 11'h440, 3'd0, "restart_slot0");
    probe_x(192, 128, 1'b0, 11'h490, 3'd0, "restart_slot1");

    frame();
    probe_x(164, 132, 1'b1, 11'h441, 3'd1, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_on",   11'(bus.text_on), 11'd0);
    chk("async_rst_addr", bus.rom_addr, 11'd0);
    chk("async_rst_busy", 11'(bus.busy), 11'd0);
    @(negedge clk) bus.frame_start = 1'b1;
    @(negedge clk) bus.frame_start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ignores_frame", 11'(bus.busy), 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_state = 0; m_rc = 0; m_frm = 0; m_bc = 0; m_blink = 1'b1;
    for (int i = 0; i < MSG_LEN; i++) m_slot[i] = '0;
    frame();
    probe_x(160, 128, 1'b0, 11'h000, 3'd0, "cleared_slot0");
    wr(5'd0, 7'h41);
    probe_x(160, 128, 1'b1, 11'h410, 3'd0, "rewritten_slot0");
    probe_m(200, 160, "rewritten_model");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end
endmodule
